mmio_input_port: RTL

- Memory-mapped input peripheral on the proc/memory bus: the read-side counterpart of the write-only LED register at address 0x000F.
- Synchronises and debounces board switches and keys, latches key-press events, and returns register contents to the processor.
- Output `rdata` and `rd_hit` are muxed onto `din` ahead of memory data in the top level.
- Read latency matches the synchronous RAM: 1 cycle.

---
 rtl/mmio_pkg.sv | 24 ++
 rtl/debounce_bit.sv | 53 +++++
 rtl/mmio_input_port.sv | 113 +++++++++++
 3 files changed

// File: rtl/mmio_pkg.sv
// Shared bus map for the proc/memory bus peripherals: LED register address and
// input-port register offsets, plus the window-decode helper.
package mmio_pkg;

   localparam logic [15:0] LED_ADDR = 16'h000F;
   localparam int          NUM_REGS = 4;

   typedef enum logic [1:0] {
      OFF_SW_DATA  = 2'd0,
      OFF_KEY_DATA = 2'd1,
      OFF_KEY_EDGE = 2'd2,
      OFF_IRQ_MASK = 2'd3
   } reg_off_e;

   // 17-bit compare so a base near the top of the map cannot wrap into low addresses.
   function automatic logic addr_in_window(input logic [15:0] addr, input logic [15:0] base);
      logic [16:0] a;
      logic [16:0] b;
      a = {1'b0, addr};
      b = {1'b0, base};
      return (a >= b) && (a < (b + 17'(NUM_REGS)));
   endfunction

endpackage

// File: rtl/debounce_bit.sv
// Two-flop synchroniser plus stability counter for one asynchronous input bit.
// RESET_VAL is the raw idle level; clean is reported relative to it (1 = active).
module debounce_bit
   import mmio_pkg::*;
#(
   parameter int unsigned DEBOUNCE_CYCLES = 50000,
   parameter logic        RESET_VAL       = 1'b0
)(
   input  logic clk,
   input  logic reset,
   input  logic raw,
   output logic clean,
   output logic rise
);

   localparam int             CW       = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam logic [CW-1:0]  CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

   logic          sync1_reg;
   logic          sync2_reg;
   logic          clean_reg;
   logic [CW-1:0] cnt_reg;
   logic          sample;
   logic          settle;

   assign sample = sync2_reg ^ RESET_VAL;
   assign settle = (sample != clean_reg) && (cnt_reg == CNT_LAST);

   always_ff @(posedge clk) begin
      if (reset) begin
         sync1_reg <= RESET_VAL;
         sync2_reg <= RESET_VAL;
         clean_reg <= 1'b0;
         cnt_reg   <= '0;
      end else begin
         sync1_reg <= raw;
         sync2_reg <= sync1_reg;
         // Counter never passes CNT_LAST: it either clears on settle or on a matching sample.
         if ((sample == clean_reg) || settle) begin
            cnt_reg <= '0;
         end else begin
            cnt_reg <= cnt_reg + CW'(1);
         end
         if (settle) begin
            clean_reg <= sample;
         end
      end
   end

   assign clean = clean_reg;
   assign rise  = settle & sample;

endmodule

// File: rtl/mmio_input_port.sv
// Memory-mapped switch/key input port: debounced inputs, latched key presses,
// interrupt mask and a one-cycle registered read path.
module mmio_input_port
   import mmio_pkg::*;
#(
   parameter logic [15:0] BASE_ADDR       = 16'h0010,
   parameter int unsigned DEBOUNCE_CYCLES = 16'd50000,
   parameter int          NUM_SW          = 10,
   parameter int          NUM_KEY         = 4
)(
   input  logic               clk,
   input  logic               reset,
   input  logic [15:0]        realaddr,
   input  logic               W,
   input  logic [31:0]        dout,
   input  logic [NUM_SW-1:0]  sw_in,
   input  logic [NUM_KEY-1:0] key_in,
   output logic [31:0]        rdata,
   output logic               rd_hit,
   output logic               irq
);

   localparam int NUM_IN = NUM_SW + NUM_KEY;

   logic [NUM_IN-1:0]  in_raw;
   logic [NUM_IN-1:0]  in_clean;
   logic [NUM_IN-1:0]  in_rise;
   logic [NUM_SW-1:0]  sw_db;
   logic [NUM_KEY-1:0] key_db;
   logic [NUM_KEY-1:0] key_press;

   assign in_raw = {key_in, sw_in};

   // Keys idle high on the board, so their instances undo that after the synchroniser.
   genvar gi;
   generate
      for (gi = 0; gi < NUM_IN; gi++) begin : g_db
         debounce_bit #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .RESET_VAL       ((gi >= NUM_SW) ? 1'b1 : 1'b0)
         ) u_db (
            .clk   (clk),
            .reset (reset),
            .raw   (in_raw[gi]),
            .clean (in_clean[gi]),
            .rise  (in_rise[gi])
         );
      end
   endgenerate

   assign sw_db     = in_clean[NUM_SW-1:0];
   assign key_db    = in_clean[NUM_IN-1:NUM_SW];
   assign key_press = in_rise[NUM_IN-1:NUM_SW];

   logic unused_bits;
   assign unused_bits = ^{dout[31:NUM_KEY], in_rise[NUM_SW-1:0]};

   logic       in_window;
   reg_off_e   off;

   assign in_window = addr_in_window(realaddr, BASE_ADDR);
   assign off       = reg_off_e'(2'(realaddr - BASE_ADDR));

   logic [NUM_KEY-1:0] key_edge_reg, key_edge_next;
   logic [NUM_KEY-1:0] irq_mask_reg, irq_mask_next;
   logic [31:0]        rdata_reg, rdata_next;
   logic               rd_hit_reg, rd_hit_next;

   always_comb begin
      key_edge_next = key_edge_reg;
      irq_mask_next = irq_mask_reg;
      rdata_next    = '0;
      rd_hit_next   = 1'b0;
      if (in_window && W) begin
         case (off)
            OFF_KEY_EDGE: key_edge_next = key_edge_reg & ~dout[NUM_KEY-1:0];
            OFF_IRQ_MASK: irq_mask_next = dout[NUM_KEY-1:0];
            default:      ;
         endcase
      end
      // A press landing in the same cycle as its W1C must survive.
      key_edge_next = key_edge_next | key_press;
      if (in_window && !W) begin
         rd_hit_next = 1'b1;
         case (off)
            OFF_SW_DATA:  rdata_next[NUM_SW-1:0]  = sw_db;
            OFF_KEY_DATA: rdata_next[NUM_KEY-1:0] = key_db;
            OFF_KEY_EDGE: rdata_next[NUM_KEY-1:0] = key_edge_reg;
            OFF_IRQ_MASK: rdata_next[NUM_KEY-1:0] = irq_mask_reg;
            default:      ;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         key_edge_reg <= '0;
         irq_mask_reg <= '0;
         rdata_reg    <= '0;
         rd_hit_reg   <= 1'b0;
      end else begin
         key_edge_reg <= key_edge_next;
         irq_mask_reg <= irq_mask_next;
         rdata_reg    <= rdata_next;
         rd_hit_reg   <= rd_hit_next;
      end
   end

   assign rdata  = rdata_reg;
   assign rd_hit = rd_hit_reg;
   assign irq    = |(key_edge_reg & irq_mask_reg);

endmodule
